// File: rtl/matrix_add_seq_pkg.sv
// Shared constants for the matrix add sequencer: element width, maximum
// matrix dimension, derived bus widths and the FSM state encoding.
package matrix_add_seq_pkg;
  localparam int ELEM_W   = 8;
  localparam int MAX_DIM  = 5;
  localparam int MAT_BITS = MAX_DIM * MAX_DIM * ELEM_W;  // 200
  localparam int BUS_W    = 2 * MAT_BITS;                // 400

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD_A  = 3'd1;
  localparam logic [2:0] S_LOAD_B  = 3'd2;
  localparam logic [2:0] S_COMPUTE = 3'd3;
  localparam logic [2:0] S_DRAIN   = 3'd4;
endpackage

// File: rtl/matrix_add_seq_add_unit.sv
// AddUnit: element-wise sum of two MAX_DIM x MAX_DIM matrices packed on one bus.
//   matrices_in  : A in the low MAT bits, B in the high MAT bits, row-major
//   m, n         : active dimensions; valid is low when either is out of 1..MAX_DIM
//   matrices_out : A+B per element, wrapping at ELEM_W bits
//   valid        : dimensions are legal
module add_unit #(
  parameter int ELEM_W  = 8,
  parameter int MAX_DIM = 5
) (
  input  logic [2*MAX_DIM*MAX_DIM*ELEM_W-1:0] matrices_in,
  input  logic [2:0]                          m,
  input  logic [2:0]                          n,
  output logic [MAX_DIM*MAX_DIM*ELEM_W-1:0]   matrices_out,
  output logic                                valid
);
  localparam int         MAT     = MAX_DIM * MAX_DIM * ELEM_W;
  localparam logic [2:0] DIM_MAX = 3'(MAX_DIM);

  // Inactive slots hold zero in both operands, so summing every slot is harmless.
  for (genvar i = 0; i < MAX_DIM * MAX_DIM; i++) begin : g_elem
    assign matrices_out[i*ELEM_W +: ELEM_W] =
      matrices_in[i*ELEM_W +: ELEM_W] + matrices_in[MAT + i*ELEM_W +: ELEM_W];
  end

  assign valid = (m != 3'd0) && (m <= DIM_MAX) && (n != 3'd0) && (n <= DIM_MAX);
endmodule

// File: rtl/matrix_add_seq.sv
// matrix_add_seq: accepts an m x n dimension config, streams in A then B
// (row-major), adds them in AddUnit and streams the result out row-major.
//   clk, reset (async, active low), abort (sync, back to IDLE)
//   cfg_valid/cfg_ready, cfg_m, cfg_n : dimension handshake
//   in_valid/in_ready, in_data        : operand element stream
//   out_valid/out_ready, out_data, out_last : result element stream
//   busy : not IDLE;  err : one-cycle pulse on bad config or invalid sum
module matrix_add_seq
  import matrix_add_seq_pkg::*;
#(
  parameter int ELEM_W  = matrix_add_seq_pkg::ELEM_W,
  parameter int MAX_DIM = matrix_add_seq_pkg::MAX_DIM
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              abort,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [2:0]        cfg_m,
  input  logic [2:0]        cfg_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ELEM_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ELEM_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              err
);
  localparam int         MAT     = MAX_DIM * MAX_DIM * ELEM_W;
  localparam int         BUS     = 2 * MAT;
  localparam int         WR_W    = $clog2(BUS);
  localparam int         RD_W    = $clog2(MAT);
  localparam logic [2:0] DIM_MAX = 3'(MAX_DIM);

  logic [2:0]     state;
  logic [2:0]     r, c, m, n;
  logic [BUS-1:0] opbuf;
  logic [MAT-1:0] res;
  logic [MAT-1:0] sum;
  logic           sum_valid;
  logic           err_q;

  logic            cfg_ok, last_rc;
  logic [WR_W-1:0] wr_off;
  logic [RD_W-1:0] rd_off;

  assign cfg_ok  = (cfg_m != 3'd0) && (cfg_m <= DIM_MAX) &&
                   (cfg_n != 3'd0) && (cfg_n <= DIM_MAX);
  assign last_rc = (r == m - 3'd1) && (c == n - 3'd1);
  // Slots are laid out on a fixed MAX_DIM stride regardless of n.
  assign wr_off  = WR_W'(((state == S_LOAD_B) ? MAT : 0) +
                         (int'(r) * MAX_DIM + int'(c)) * ELEM_W);
  assign rd_off  = RD_W'((int'(r) * MAX_DIM + int'(c)) * ELEM_W);

  add_unit #(.ELEM_W(ELEM_W), .MAX_DIM(MAX_DIM)) u_add (
    .matrices_in  (opbuf),
    .m            (m),
    .n            (n),
    .matrices_out (sum),
    .valid        (sum_valid)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      r     <= '0;
      c     <= '0;
      m     <= '0;
      n     <= '0;
      opbuf <= '0;
      res   <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (abort) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: if (cfg_valid) begin
            if (cfg_ok) begin
              m     <= cfg_m;
              n     <= cfg_n;
              opbuf <= '0;  // unused slots must read as zero in AddUnit
              r     <= '0;
              c     <= '0;
              state <= S_LOAD_A;
            end else begin
              err_q <= 1'b1;
            end
          end
          S_LOAD_A, S_LOAD_B: if (in_valid) begin
            opbuf[wr_off +: ELEM_W] <= in_data;
            if (last_rc) begin
              r     <= '0;
              c     <= '0;
              state <= (state == S_LOAD_A) ? S_LOAD_B : S_COMPUTE;
            end else if (c == n - 3'd1) begin
              c <= '0;
              r <= r + 3'd1;
            end else begin
              c <= c + 3'd1;
            end
          end
          S_COMPUTE: begin
            res <= sum;
            if (sum_valid) begin
              r     <= '0;
              c     <= '0;
              state <= S_DRAIN;
            end else begin
              err_q <= 1'b1;
              state <= S_IDLE;
            end
          end
          S_DRAIN: if (out_ready) begin
            if (last_rc) begin
              state <= S_IDLE;
            end else if (c == n - 3'd1) begin
              c <= '0;
              r <= r + 3'd1;
            end else begin
              c <= c + 3'd1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Outputs decode from state so reset and abort clear them without extra flops.
  assign cfg_ready = (state == S_IDLE);
  assign in_ready  = (state == S_LOAD_A) || (state == S_LOAD_B);
  assign out_valid = (state == S_DRAIN);
  assign out_data  = out_valid ? res[rd_off +: ELEM_W] : '0;
  assign out_last  = out_valid && last_rc;
  assign busy      = (state != S_IDLE);
  assign err       = err_q;
endmodule

// File: tb/tb_matrix_add_seq.sv
module tb_matrix_add_seq;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       abort = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [2:0] cfg_m = '0, cfg_n = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_last;
  logic       busy;
  logic       err;

  int n_chk = 0;
  int n_err = 0;

  matrix_add_seq dut (
    .clk(clk), .reset(reset), .abort(abort),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_m(cfg_m), .cfg_n(cfg_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input logic [2:0] mm, input logic [2:0] nn);
    cfg_valid = 1'b1;
    cfg_m = mm;
    cfg_n = nn;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    int k = 0;
    in_valid = 1'b1;
    in_data = d;
    while (!in_ready && k < 20) begin
      tick();
      k++;
    end
    if (!in_ready) check("send_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic recv(input string tag, input logic [7:0] d, input logic last);
    int k = 0;
    out_ready = 1'b1;
    while (!out_valid && k < 20) begin
      tick();
      k++;
    end
    check({tag, "_valid"}, 32'(out_valid), 1);
    check({tag, "_data"}, 32'(out_data), 32'(d));
    check({tag, "_last"}, 32'(out_last), 32'(last));
    tick();
  endtask

  initial begin
    logic [7:0] a23 [6] = '{1, 2, 3, 3, 4, 5};
    logic [7:0] b23 [6] = '{3, 3, 3, 2, 2, 2};
    logic [7:0] r23 [6] = '{4, 5, 6, 5, 6, 7};
    int idx, cyc;
    logic tog;

    // Reset state
    #1;
    check("rst_cfg_ready", 32'(cfg_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_err", 32'(err), 0);
    tick();
    reset = 1'b1;
    tick();

    // 2x3 run, out_ready held high
    out_ready = 1'b1;
    do_cfg(3'd2, 3'd3);
    check("cfg_busy", 32'(busy), 1);
    check("cfg_in_ready", 32'(in_ready), 1);
    for (int i = 0; i < 6; i++) send(a23[i]);
    for (int i = 0; i < 6; i++) send(b23[i]);
    // now in the COMPUTE cycle, one after the last B acceptance
    check("lat_compute_ov", 32'(out_valid), 0);
    check("lat_compute_ir", 32'(in_ready), 0);
    tick();
    check("lat_first_ov", 32'(out_valid), 1);
    for (int i = 0; i < 6; i++) recv($sformatf("r23_%0d", i), r23[i], i == 5);
    check("r23_done_busy", 32'(busy), 0);
    check("r23_done_cfg_ready", 32'(cfg_ready), 1);

    // Bad configurations
    do_cfg(3'd0, 3'd2);
    check("bad_m_err", 32'(err), 1);
    check("bad_m_busy", 32'(busy), 0);
    check("bad_m_in_ready", 32'(in_ready), 0);
    tick();
    check("bad_m_err_drop", 32'(err), 0);
    do_cfg(3'd2, 3'd6);
    check("bad_n_err", 32'(err), 1);
    check("bad_n_busy", 32'(busy), 0);
    check("bad_n_in_ready", 32'(in_ready), 0);
    tick();
    check("bad_n_err_drop", 32'(err), 0);

    // 5x5 with out_ready toggling every cycle
    out_ready = 1'b0;
    do_cfg(3'd5, 3'd5);
    for (int i = 0; i < 25; i++) send(8'd1);
    for (int i = 0; i < 25; i++) send(8'd2);
    idx = 0;
    cyc = 0;
    tog = 1'b0;
    while (idx < 25 && cyc < 200) begin
      out_ready = tog;
      tog = ~tog;
      if (out_valid) begin
        check($sformatf("bp_data_%0d", idx), 32'(out_data), 3);
        check($sformatf("bp_last_%0d", idx), 32'(out_last), 32'(idx == 24));
        if (out_ready) idx++;
      end
      tick();
      cyc++;
    end
    check("bp_count", 32'(idx), 25);
    check("bp_done_busy", 32'(busy), 0);
    out_ready = 1'b0;

    // Abort during LOAD_B, then a fresh 1x1 run
    do_cfg(3'd2, 3'd2);
    for (int i = 0; i < 4; i++) send(8'(i + 50));
    for (int i = 0; i < 3; i++) send(8'(i + 60));
    abort = 1'b1;
    cfg_valid = 1'b1;  // abort must win over a config if it lands in IDLE too
    cfg_m = 3'd1;
    cfg_n = 3'd1;
    tick();
    abort = 1'b0;
    cfg_valid = 1'b0;
    check("abort_busy", 32'(busy), 0);
    check("abort_in_ready", 32'(in_ready), 0);
    check("abort_cfg_ready", 32'(cfg_ready), 1);
    check("abort_err", 32'(err), 0);
    abort = 1'b1;
    cfg_valid = 1'b1;
    tick();
    abort = 1'b0;
    cfg_valid = 1'b0;
    check("abort_idle_cfg_busy", 32'(busy), 0);
    check("abort_idle_cfg_err", 32'(err), 0);
    do_cfg(3'd1, 3'd1);
    send(8'd7);
    send(8'd8);
    recv("one", 8'd15, 1'b1);
    check("one_done_busy", 32'(busy), 0);

    // Reset during DRAIN
    do_cfg(3'd2, 3'd2);
    for (int i = 0; i < 4; i++) send(8'(i + 1));
    for (int i = 0; i < 4; i++) send(8'(10 * (i + 1)));
    recv("rd0", 8'd11, 1'b0);
    recv("rd1", 8'd22, 1'b0);
    check("rd_pre_ov", 32'(out_valid), 1);
    #2;
    reset = 1'b0;
    #1;
    check("rd_async_ov", 32'(out_valid), 0);
    check("rd_async_data", 32'(out_data), 0);
    check("rd_async_busy", 32'(busy), 0);
    check("rd_async_err", 32'(err), 0);
    tick();
    reset = 1'b1;
    tick();
    check("rd_rel_cfg_ready", 32'(cfg_ready), 1);
    check("rd_rel_ov", 32'(out_valid), 0);
    check("rd_rel_err", 32'(err), 0);
    out_ready = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
